// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: hazard inputs from the datapath stages, and the
// stall/flush controls plus status returned by the controller.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             IdEx_MemRead;
  logic [4:0]       IdEx_Rd;
  logic [4:0]       IfId_Rs1;
  logic [4:0]       IfId_Rs2;
  logic             IfId_UsesRs2;
  logic             Branch_Taken;
  logic             ExMem_MemRead;
  logic             ExMem_MemWrite;
  logic             Dmem_Ready;
  logic             PC_Write;
  logic             IfId_Write;
  logic             IfId_Flush;
  logic             IdEx_Write;
  logic             IdEx_Flush;
  logic             ExMem_Write;
  logic             MemWb_Flush;
  logic [CNT_W-1:0] Stall_Cnt;
  logic [CNT_W-1:0] Flush_Cnt;
  logic             Mem_Timeout;

  modport master (
    output IdEx_MemRead, IdEx_Rd, IfId_Rs1, IfId_Rs2, IfId_UsesRs2,
           Branch_Taken, ExMem_MemRead, ExMem_MemWrite, Dmem_Ready,
    input  PC_Write, IfId_Write, IfId_Flush, IdEx_Write, IdEx_Flush,
           ExMem_Write, MemWb_Flush, Stall_Cnt, Flush_Cnt, Mem_Timeout
  );

  modport slave (
    input  IdEx_MemRead, IdEx_Rd, IfId_Rs1, IfId_Rs2, IfId_UsesRs2,
           Branch_Taken, ExMem_MemRead, ExMem_MemWrite, Dmem_Ready,
    output PC_Write, IfId_Write, IfId_Flush, IdEx_Write, IdEx_Flush,
           ExMem_Write, MemWb_Flush, Stall_Cnt, Flush_Cnt, Mem_Timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory waits, branch
// redirects and load-use bubbles, with saturating perf counters and timeout flag.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state, state_next;
  logic [WC_W-1:0]  wc, wc_next;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             timeout, timeout_set;
  logic             mem_stall, load_use, br_flush;
  logic             pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic             exmem_write, memwb_flush;

  assign mem_stall = (bus.ExMem_MemRead | bus.ExMem_MemWrite) & ~bus.Dmem_Ready;
  assign load_use  = bus.IdEx_MemRead & (bus.IdEx_Rd != 5'd0) &
                     ((bus.IdEx_Rd == bus.IfId_Rs1) |
                      (bus.IfId_UsesRs2 & (bus.IdEx_Rd == bus.IfId_Rs2)));

  // Next state, wait counter and same-cycle pipeline controls
  always_comb begin
    state_next  = state;
    wc_next     = wc;
    timeout_set = 1'b0;
    br_flush    = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    memwb_flush = 1'b0;

    if (mem_stall) begin
      state_next = MEM_WAIT;
      if (state == RUN)                     wc_next = WC_W'(1);
      else if (wc != WC_W'(MEM_TIMEOUT))    wc_next = wc + WC_W'(1);
      timeout_set = (wc_next == WC_W'(MEM_TIMEOUT));
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end else begin
      state_next = RUN;
      wc_next    = '0;
      if (bus.Branch_Taken) begin
        br_flush   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end

    // Reset freezes every stage and clears in-flight control bits
    if (reset) begin
      br_flush    = 1'b0;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_write  = 1'b0;
      idex_flush  = 1'b1;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      wc      <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_next;
      wc    <= wc_next;
      if (timeout_set) timeout <= 1'b1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_flush && (flush_cnt != '1))  flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.PC_Write    = pc_write;
  assign bus.IfId_Write  = ifid_write;
  assign bus.IfId_Flush  = ifid_flush;
  assign bus.IdEx_Write  = idex_write;
  assign bus.IdEx_Flush  = idex_flush;
  assign bus.ExMem_Write = exmem_write;
  assign bus.MemWb_Flush = memwb_flush;
  assign bus.Stall_Cnt   = stall_cnt;
  assign bus.Flush_Cnt   = flush_cnt;
  assign bus.Mem_Timeout = timeout;
endmodule
